imm_decode_stage: RTL and testbench
===================================

# imm_decode_stage

Registered, parametrised immediate-decode pipeline stage that sits between instruction fetch and the register-read/execute stage of the pipelined core. It classifies each 32-bit RV instruction by format, builds the sign- or zero-extended immediate at XLEN width, and flags unsupported opcodes. Data moves through a valid/ready handshake with an optional 2-entry skid buffer for full throughput under backpressure, plus a synchronous flush for branch redirects.

## Interface
- XLEN, 32: datapath width, 32 or 64; immediates are extended to XLEN.
- DEPTH, 2: buffer entries, 1 (single register) or 2 (skid buffer, registered in_ready).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drop all buffered entries and any input on this cycle.
- in_valid  in  1  upstream offers instruction.
- in_ready  out  1  stage accepts; transfer when in_valid && in_ready.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address, passed through.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
- out_instr  out  32  instruction passed through.
- out_pc  out  XLEN  PC passed through.
- out_imm  out  XLEN  decoded immediate.
- out_type  out  3  format: 0 I, 1 S, 2 B, 3 U, 4 J, 5 R, 7 illegal.
- out_illegal  out  1  opcode not in the supported set.

## Operation
- Opcode map (instr[6:0]): 0010011, 0000011, 1100111, 1110011, 0001111 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; 0110011 -> R; instr[1:0] != 11 or any other opcode -> illegal.
- I: sext(instr[31:20]). S: sext({instr[31:25], instr[11:7]}). B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}). U: sext({instr[31:12], 12'b0}) (sign-extends bit 31 when XLEN=64). J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- Shift-immediates (opcode 0010011, funct3 001 or 101): imm = zero-extended shamt, instr[24:20] for XLEN=32, instr[25:20] for XLEN=64; funct7 bits excluded.
- CSR immediate forms (opcode 1110011, funct3[2]=1): imm = zero-extended instr[19:15].
- R and illegal: out_imm = 0; illegal sets out_illegal=1, out_type=7. Illegal entries still flow through the handshake.
- Decode is combinational on in_instr; the result is captured into the buffer at acceptance.
- DEPTH=1: in_ready = !out_valid || out_ready (combinational pass-through).
- DEPTH=2: in_ready = skid entry empty (registered). Main entry drives outputs; when main is held (out_valid && !out_ready) and input accepted, input goes to skid; on next drain, skid moves to main. Strict FIFO order.
- Flush: next cycle out_valid=0, all entries empty; input offered on the flush cycle is discarded (in_ready may be 1; transfer is counted but dropped). Flush has priority over acceptance and drain.
- Reset: as flush, plus all output data registers cleared.

## Timing
- Reset values: out_valid=0, out_instr=0, out_pc=0, out_imm=0, out_type=0, out_illegal=0; in_ready=0 while rst high, 1 the cycle after rst falls.
- Latency: accepted on edge N -> out_valid and data at N+1 (no combinational in->out path).
- Throughput: one instruction per cycle with out_ready held high, both DEPTHs.
- Stability: while out_valid && !out_ready, all out_* hold constant.
- Full (DEPTH=2): both entries occupied -> in_ready=0 the following cycle; single out_ready pulse -> in_ready=1 next cycle.
- Simultaneous accept and drain with one entry: occupancy unchanged, new data appears next cycle.
- rst or flush mid-stall: entries dropped, no output of stale data.

## Test plan
- XLEN=32: 0xFFF00093 (addi x1,x0,-1) -> one cycle later out_imm=0xFFFFFFFF, out_type=0; 0xFE112E23 (sw x1,-4(x2)) -> 0xFFFFFFFC, type 1.
- 0x0010006F (jal x0,+2048) -> out_imm=0x00000800, type 4; 0x4030D093 (srai x1,x1,3) -> out_imm=0x00000003, not 0x403.
- XLEN=64: 0x800000B7 (lui x1,0x80000) -> out_imm=0xFFFFFFFF80000000, type 3.
- 0x0000007F -> out_illegal=1, out_type=7, out_imm=0; 0x002081B3 (add) -> type 5, imm 0, illegal 0.
- DEPTH=2, out_ready=0, push A,B,C back-to-back -> A,B accepted, in_ready=0, C held; raise out_ready -> A,B,C emerge in order on consecutive cycles, outputs stable while stalled.
- Full buffer plus flush pulse with in_valid=1 -> next cycle out_valid=0, offered instruction never emerges; rst asserted mid-stream -> all outputs zero next cycle, in_ready=0 until rst falls.

Source files
------------

// File: rtl/imm_decode_stage_if.sv
// Handshake bundle for the immediate-decode stage: upstream offer, downstream result and flush.
// The stage uses the slave modport; the driving environment uses master.
interface imm_decode_stage_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_type;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_type, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_type, out_illegal
  );
endinterface

// File: rtl/imm_decode_stage.sv
// Registered RV immediate-decode stage: classifies the instruction format, builds the
// XLEN-wide immediate and buffers the result in a 1- or 2-entry valid/ready stage.
module imm_decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input logic               clk,
  input logic               rst,
  imm_decode_stage_if.slave bus
);

  localparam logic [2:0] TypeI       = 3'd0;
  localparam logic [2:0] TypeS       = 3'd1;
  localparam logic [2:0] TypeB       = 3'd2;
  localparam logic [2:0] TypeU       = 3'd3;
  localparam logic [2:0] TypeJ       = 3'd4;
  localparam logic [2:0] TypeR       = 3'd5;
  localparam logic [2:0] TypeIllegal = 3'd7;

  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpReg    = 7'b0110011;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            illegal;
  } entry_t;

  logic [31:0]     ins;
  logic [2:0]      funct3;
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_type;
  logic            dec_illegal;
  entry_t          dec_entry;

  assign ins    = bus.in_instr;
  assign funct3 = ins[14:12];

  // Every immediate fits in 32 bits already sign-correct; zero-extended forms have bit 31 clear.
  always_comb begin
    imm32       = '0;
    dec_type    = TypeI;
    dec_illegal = 1'b0;
    case (ins[6:0])
      OpImm: begin
        if (funct3[1:0] == 2'b01) begin
          imm32[4:0] = ins[24:20];
          if (XLEN == 64) imm32[5] = ins[25];
        end else begin
          imm32 = {{20{ins[31]}}, ins[31:20]};
        end
      end
      OpSystem: begin
        if (funct3[2]) imm32 = {27'b0, ins[19:15]};
        else           imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      OpLoad, OpJalr, OpFence: imm32 = {{20{ins[31]}}, ins[31:20]};
      OpStore: begin
        dec_type = TypeS;
        imm32    = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OpBranch: begin
        dec_type = TypeB;
        imm32    = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OpLui, OpAuipc: begin
        dec_type = TypeU;
        imm32    = {ins[31:12], 12'h000};
      end
      OpJal: begin
        dec_type = TypeJ;
        imm32    = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OpReg: dec_type = TypeR;
      default: begin
        dec_type    = TypeIllegal;
        dec_illegal = 1'b1;
      end
    endcase
  end

  if (XLEN > 32) begin : g_ext
    assign dec_imm = {{(XLEN-32){imm32[31]}}, imm32};
  end else begin : g_noext
    assign dec_imm = imm32;
  end

  always_comb begin
    dec_entry         = '0;
    dec_entry.instr   = ins;
    dec_entry.pc      = bus.in_pc;
    dec_entry.imm     = dec_imm;
    dec_entry.typ     = dec_type;
    dec_entry.illegal = dec_illegal;
  end

  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   ready_en_q;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   accept, drain;

  // ready_en_q keeps in_ready low through reset and for the first cycle after it.
  assign bus.in_ready = ready_en_q &&
                        ((DEPTH == 1) ? (!main_valid_q || bus.out_ready) : !skid_valid_q);
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = main_valid_q && bus.out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Main is stalled; only reachable with DEPTH=2 since in_ready is low otherwise.
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_en_q   <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_en_q   <= 1'b1;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign bus.out_valid   = main_valid_q;
  assign bus.out_instr   = main_q.instr;
  assign bus.out_pc      = main_q.pc;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_type    = main_q.typ;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench: table vectors, handshake corner sequences and a randomized run
// against a queue-based reference model, on XLEN=32/64 DEPTH=2 and XLEN=32 DEPTH=1.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        in_valid_a, out_ready_a, in_valid_b, out_ready_b;

  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32)) bus32 ();
  imm_decode_stage_if #(.XLEN(64)) bus64 ();
  imm_decode_stage_if #(.XLEN(32)) bus1 ();

  assign bus32.flush     = flush;
  assign bus32.in_valid  = in_valid_a;
  assign bus32.in_instr  = instr;
  assign bus32.in_pc     = pc[31:0];
  assign bus32.out_ready = out_ready_a;
  assign bus64.flush     = flush;
  assign bus64.in_valid  = in_valid_a;
  assign bus64.in_instr  = instr;
  assign bus64.in_pc     = pc;
  assign bus64.out_ready = out_ready_a;
  assign bus1.flush      = flush;
  assign bus1.in_valid   = in_valid_b;
  assign bus1.in_instr   = instr;
  assign bus1.in_pc      = pc[31:0];
  assign bus1.out_ready  = out_ready_b;

  imm_decode_stage #(.XLEN(32), .DEPTH(2)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  imm_decode_stage #(.XLEN(64), .DEPTH(2)) dut64 (.clk(clk), .rst(rst), .bus(bus64));
  imm_decode_stage #(.XLEN(32), .DEPTH(1)) dut1  (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct packed {
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  typ;
    logic        ill;
  } dec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    dec_t        d;
  } ent_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] e64;
    logic [31:0] e32;
    logic [2:0]  typ;
    logic        ill;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the format rules, using signed field values.
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t               r;
    logic signed [11:0] s12;
    logic signed [12:0] s13;
    logic signed [20:0] s21;
    logic signed [31:0] s32;
    r = '0;
    case (w[6:0])
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin s12 = w[31:20]; r.imm64 = 64'(s12); end
      7'h23: begin s12 = {w[31:25], w[11:7]}; r.imm64 = 64'(s12); r.typ = 3'd1; end
      7'h63: begin
        s13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; r.imm64 = 64'(s13); r.typ = 3'd2;
      end
      7'h37, 7'h17: begin s32 = {w[31:12], 12'h000}; r.imm64 = 64'(s32); r.typ = 3'd3; end
      7'h6F: begin
        s21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; r.imm64 = 64'(s21); r.typ = 3'd4;
      end
      7'h33:   r.typ = 3'd5;
      default: begin r.typ = 3'd7; r.ill = 1'b1; end
    endcase
    r.imm32 = r.imm64[31:0];
    if (w[6:0] == 7'h13 && w[13:12] == 2'b01) begin
      r.imm64 = 64'(w[25:20]);
      r.imm32 = 32'(w[24:20]);
    end
    if (w[6:0] == 7'h73 && w[14]) begin
      r.imm64 = 64'(w[19:15]);
      r.imm32 = 32'(w[19:15]);
    end
    return r;
  endfunction

  function automatic ent_t make_ent(input logic [31:0] w, input logic [63:0] p);
    ent_t e;
    e.instr = w;
    e.pc    = p;
    e.d     = ref_decode(w);
    return e;
  endfunction

  task automatic check_pair(input string tag, input bit ev, input ent_t e);
    check({tag, " valid32"}, 64'(bus32.out_valid), 64'(ev));
    check({tag, " valid64"}, 64'(bus64.out_valid), 64'(ev));
    if (ev) begin
      check({tag, " instr32"}, 64'(bus32.out_instr), 64'(e.instr));
      check({tag, " pc32"}, 64'(bus32.out_pc), 64'(e.pc[31:0]));
      check({tag, " imm32"}, 64'(bus32.out_imm), 64'(e.d.imm32));
      check({tag, " type32"}, 64'(bus32.out_type), 64'(e.d.typ));
      check({tag, " ill32"}, 64'(bus32.out_illegal), 64'(e.d.ill));
      check({tag, " instr64"}, 64'(bus64.out_instr), 64'(e.instr));
      check({tag, " pc64"}, bus64.out_pc, e.pc);
      check({tag, " imm64"}, bus64.out_imm, e.d.imm64);
      check({tag, " type64"}, 64'(bus64.out_type), 64'(e.d.typ));
    end
  endtask

  task automatic check_one(input string tag, input bit ev, input ent_t e);
    check({tag, " valid1"}, 64'(bus1.out_valid), 64'(ev));
    if (ev) begin
      check({tag, " instr1"}, 64'(bus1.out_instr), 64'(e.instr));
      check({tag, " pc1"}, 64'(bus1.out_pc), 64'(e.pc[31:0]));
      check({tag, " imm1"}, 64'(bus1.out_imm), 64'(e.d.imm32));
      check({tag, " type1"}, 64'(bus1.out_type), 64'(e.d.typ));
      check({tag, " ill1"}, 64'(bus1.out_illegal), 64'(e.d.ill));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " valid32"}, 64'(bus32.out_valid), 64'd0);
    check({tag, " instr32"}, 64'(bus32.out_instr), 64'd0);
    check({tag, " pc32"}, 64'(bus32.out_pc), 64'd0);
    check({tag, " imm32"}, 64'(bus32.out_imm), 64'd0);
    check({tag, " type32"}, 64'(bus32.out_type), 64'd0);
    check({tag, " ill32"}, 64'(bus32.out_illegal), 64'd0);
    check({tag, " imm64"}, bus64.out_imm, 64'd0);
    check({tag, " pc64"}, bus64.out_pc, 64'd0);
    check({tag, " valid1"}, 64'(bus1.out_valid), 64'd0);
    check({tag, " imm1"}, 64'(bus1.out_imm), 64'd0);
    check({tag, " rdy32"}, 64'(bus32.in_ready), 64'd0);
    check({tag, " rdy1"}, 64'(bus1.in_ready), 64'd0);
  endtask

  vec_t       vt[17];
  ent_t       blank;
  ent_t       ea, eb, ec, ed;
  ent_t       mq[$];
  ent_t       mq1[$];
  logic [6:0] ops[12];

  initial begin
    vt[0]  = '{32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, 32'hFFFFFFFF, 3'd0, 1'b0};
    vt[1]  = '{32'hFE112E23, 64'hFFFFFFFF_FFFFFFFC, 32'hFFFFFFFC, 3'd1, 1'b0};
    vt[2]  = '{32'h0010006F, 64'h00000000_00000800, 32'h00000800, 3'd4, 1'b0};
    vt[3]  = '{32'h4030D093, 64'h00000000_00000003, 32'h00000003, 3'd0, 1'b0};
    vt[4]  = '{32'h800000B7, 64'hFFFFFFFF_80000000, 32'h80000000, 3'd3, 1'b0};
    vt[5]  = '{32'h0000007F, 64'h0, 32'h0, 3'd7, 1'b1};
    vt[6]  = '{32'h002081B3, 64'h0, 32'h0, 3'd5, 1'b0};
    vt[7]  = '{32'hFE000EE3, 64'hFFFFFFFF_FFFFFFFC, 32'hFFFFFFFC, 3'd2, 1'b0};
    vt[8]  = '{32'hFFFFD073, 64'h00000000_0000001F, 32'h0000001F, 3'd0, 1'b0};
    vt[9]  = '{32'hFFF09073, 64'hFFFFFFFF_FFFFFFFF, 32'hFFFFFFFF, 3'd0, 1'b0};
    vt[10] = '{32'h02009093, 64'h00000000_00000020, 32'h00000000, 3'd0, 1'b0};
    vt[11] = '{32'h12345017, 64'h00000000_12345000, 32'h12345000, 3'd3, 1'b0};
    vt[12] = '{32'h00000011, 64'h0, 32'h0, 3'd7, 1'b1};
    vt[13] = '{32'h80002003, 64'hFFFFFFFF_FFFFF800, 32'hFFFFF800, 3'd0, 1'b0};
    vt[14] = '{32'h7FF00067, 64'h00000000_000007FF, 32'h000007FF, 3'd0, 1'b0};
    vt[15] = '{32'h0FF0000F, 64'h00000000_000000FF, 32'h000000FF, 3'd0, 1'b0};
    vt[16] = '{32'hFFDFF06F, 64'hFFFFFFFF_FFFFFFFC, 32'hFFFFFFFC, 3'd4, 1'b0};
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};
    blank = '0;

    rst = 1'b1; flush = 1'b0; instr = '0; pc = '0;
    in_valid_a = 1'b0; out_ready_a = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    #1;
    check("rdy32 just after rst falls", 64'(bus32.in_ready), 64'd0);
    @(negedge clk);
    check("rdy32 after rst", 64'(bus32.in_ready), 64'd1);
    check("rdy64 after rst", 64'(bus64.in_ready), 64'd1);
    check("rdy1 after rst", 64'(bus1.in_ready), 64'd1);

    // Table vectors, back-to-back with out_ready high on all three instances.
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    for (int i = 0; i < 17; i++) begin
      instr = vt[i].instr; pc = {vt[i].instr, ~vt[i].instr};
      in_valid_a = 1'b1; in_valid_b = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d valid32", i), 64'(bus32.out_valid), 64'd1);
      check($sformatf("vec%0d instr32", i), 64'(bus32.out_instr), 64'(vt[i].instr));
      check($sformatf("vec%0d imm32", i), 64'(bus32.out_imm), 64'(vt[i].e32));
      check($sformatf("vec%0d type32", i), 64'(bus32.out_type), 64'(vt[i].typ));
      check($sformatf("vec%0d ill32", i), 64'(bus32.out_illegal), 64'(vt[i].ill));
      check($sformatf("vec%0d imm64", i), bus64.out_imm, vt[i].e64);
      check($sformatf("vec%0d pc64", i), bus64.out_pc, {vt[i].instr, ~vt[i].instr});
      check($sformatf("vec%0d type64", i), 64'(bus64.out_type), 64'(vt[i].typ));
      check($sformatf("vec%0d imm1", i), 64'(bus1.out_imm), 64'(vt[i].e32));
      check($sformatf("vec%0d type1", i), 64'(bus1.out_type), 64'(vt[i].typ));
    end
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    @(negedge clk);
    check_pair("drain", 1'b0, blank);

    // Skid: stall downstream, push A, B, C.
    ea = make_ent(32'hFFF00093, 64'h11); eb = make_ent(32'hFE112E23, 64'h22);
    ec = make_ent(32'h0010006F, 64'h33);
    out_ready_a = 1'b0;
    instr = ea.instr; pc = ea.pc; in_valid_a = 1'b1;
    @(negedge clk);
    check_pair("skidA", 1'b1, ea);
    check("skidA rdy", 64'(bus32.in_ready), 64'd1);
    instr = eb.instr; pc = eb.pc;
    @(negedge clk);
    check_pair("skidB", 1'b1, ea);
    check("skidB rdy", 64'(bus32.in_ready), 64'd0);
    instr = ec.instr; pc = ec.pc;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_pair("stall", 1'b1, ea);
      check("stall rdy", 64'(bus64.in_ready), 64'd0);
    end
    out_ready_a = 1'b1;
    @(negedge clk);
    check_pair("emitB", 1'b1, eb);
    check("emitB rdy", 64'(bus32.in_ready), 64'd1);
    @(negedge clk);
    check_pair("emitC", 1'b1, ec);
    in_valid_a = 1'b0;
    @(negedge clk);
    check_pair("empty", 1'b0, blank);

    // Flush with a full buffer and an instruction on offer.
    ed = make_ent(32'h12345017, 64'h44);
    out_ready_a = 1'b0;
    instr = ea.instr; pc = ea.pc; in_valid_a = 1'b1;
    @(negedge clk);
    instr = eb.instr; pc = eb.pc;
    @(negedge clk);
    check("full rdy", 64'(bus32.in_ready), 64'd0);
    flush = 1'b1; instr = ed.instr; pc = ed.pc;
    @(negedge clk);
    flush = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
    check_pair("flush full", 1'b0, blank);
    check("flush rdy", 64'(bus32.in_ready), 64'd1);
    repeat (2) begin
      @(negedge clk);
      check_pair("post flush", 1'b0, blank);
    end

    // Flush while in_ready is high: the offered word is dropped.
    out_ready_a = 1'b0;
    instr = ea.instr; pc = ea.pc; in_valid_a = 1'b1;
    @(negedge clk);
    flush = 1'b1; instr = ed.instr; pc = ed.pc; in_valid_b = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0; out_ready_a = 1'b1;
    check_pair("flush open", 1'b0, blank);
    check_one("flush open", 1'b0, blank);
    @(negedge clk);
    check_pair("flush open2", 1'b0, blank);
    check_one("flush open2", 1'b0, blank);

    // DEPTH=1: in_ready follows out_ready combinationally while holding.
    out_ready_b = 1'b0; instr = ea.instr; pc = ea.pc; in_valid_b = 1'b1;
    @(negedge clk);
    check_one("d1 hold", 1'b1, ea);
    check("d1 rdy held", 64'(bus1.in_ready), 64'd0);
    out_ready_b = 1'b1;
    #1;
    check("d1 rdy comb", 64'(bus1.in_ready), 64'd1);
    instr = eb.instr; pc = eb.pc;
    @(negedge clk);
    check_one("d1 pass", 1'b1, eb);
    in_valid_b = 1'b0;
    @(negedge clk);
    check_one("d1 empty", 1'b0, blank);

    // Reset during a stall.
    out_ready_a = 1'b0; out_ready_b = 1'b0;
    instr = ec.instr; pc = ec.pc; in_valid_a = 1'b1; in_valid_b = 1'b1;
    @(negedge clk);
    rst = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0;
    @(negedge clk);
    check_zero("rst mid");
    rst = 1'b0;
    #1;
    check("rst fall rdy32", 64'(bus32.in_ready), 64'd0);
    @(negedge clk);
    check("rst done rdy32", 64'(bus32.in_ready), 64'd1);
    check_pair("rst done", 1'b0, blank);

    // Randomized run against the queue model.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] rnd;
      logic [6:0]  op;
      bit          rdy_a, rdy_b;
      ent_t        e;
      if (c != 0) @(negedge clk);
      check_pair("rnd", mq.size() > 0, (mq.size() > 0) ? mq[0] : blank);
      check_one("rnd", mq1.size() > 0, (mq1.size() > 0) ? mq1[0] : blank);
      rnd = $urandom();
      op  = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) op = rnd[6:0];
      instr       = {rnd[31:7], op};
      pc          = {$urandom(), $urandom()};
      in_valid_a  = $urandom_range(0, 3) != 0;
      out_ready_a = $urandom_range(0, 2) != 0;
      in_valid_b  = $urandom_range(0, 3) != 0;
      out_ready_b = $urandom_range(0, 2) != 0;
      flush       = $urandom_range(0, 40) == 0;
      #1;
      rdy_a = mq.size() < 2;
      rdy_b = (mq1.size() == 0) || out_ready_b;
      check("rnd rdy32", 64'(bus32.in_ready), 64'(rdy_a));
      check("rnd rdy64", 64'(bus64.in_ready), 64'(rdy_a));
      check("rnd rdy1", 64'(bus1.in_ready), 64'(rdy_b));
      e = make_ent(instr, pc);
      if (flush) begin
        mq.delete();
        mq1.delete();
      end else begin
        if (mq.size() > 0 && out_ready_a) void'(mq.pop_front());
        if (in_valid_a && rdy_a) mq.push_back(e);
        if (mq1.size() > 0 && out_ready_b) void'(mq1.pop_front());
        if (in_valid_b && rdy_b) mq1.push_back(e);
      end
    end
    @(negedge clk);
    check_pair("rnd end", mq.size() > 0, (mq.size() > 0) ? mq[0] : blank);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
